// File: rtl/dtcm_arbiter.sv
// Two-master arbiter in front of a single-port DTCM SRAM.
// Round-robin between m0 (LSU) and m1 (loader/debug), with a bounded m1 lock and one-cycle responses.
module dtcm_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [AW-1:0]     m0_req_addr,
    input  logic [DW-1:0]     m0_req_wdata,
    input  logic [DW/8-1:0]   m0_req_wem,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [AW-1:0]     m1_req_addr,
    input  logic [DW-1:0]     m1_req_wdata,
    input  logic [DW/8-1:0]   m1_req_wem,
    input  logic              m1_lock,
    output logic              m0_rsp_valid,
    output logic [DW-1:0]     m0_rsp_rdata,
    output logic              m1_rsp_valid,
    output logic [DW-1:0]     m1_rsp_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_din,
    output logic [DW/8-1:0]   ram_wem,
    input  logic [DW-1:0]     ram_dout
);
    localparam int MW = DW / 8;
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          rr_ptr;
    logic          lock_held;
    logic [CW-1:0] lock_cnt;
    logic          pick_m1;
    logic          gnt0;
    logic          gnt1;
    logic          vld0_p1;
    logic          vld1_p1;
    logic          rd_p1;

    // Grant selection: lock budget exhaustion beats the lock, the lock beats round-robin.
    always_comb begin
        pick_m1 = m1_req_valid;
        if (m0_req_valid && m1_req_valid) begin
            if (lock_cnt == CW'(LOCK_MAX))
                pick_m1 = 1'b0;
            else if (lock_held && m1_lock)
                pick_m1 = 1'b1;
            else
                pick_m1 = rr_ptr;
        end
        gnt0 = !rst && m0_req_valid && !pick_m1;
        gnt1 = !rst && m1_req_valid && pick_m1;
    end

    assign m0_req_ready = gnt0;
    assign m1_req_ready = gnt1;

    // Stage p0: winner's fields go straight to the SRAM in the accept cycle.
    always_comb begin
        ram_cs   = gnt0 || gnt1;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        ram_wem  = '0;
        if (gnt0) begin
            ram_we   = m0_req_we;
            ram_addr = m0_req_addr;
            ram_din  = m0_req_wdata;
            ram_wem  = m0_req_we ? m0_req_wem : MW'(0);
        end else if (gnt1) begin
            ram_we   = m1_req_we;
            ram_addr = m1_req_addr;
            ram_din  = m1_req_wdata;
            ram_wem  = m1_req_we ? m1_req_wem : MW'(0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            lock_held <= 1'b0;
            lock_cnt  <= '0;
            vld0_p1   <= 1'b0;
            vld1_p1   <= 1'b0;
            rd_p1     <= 1'b0;
        end else begin
            if (gnt0 || gnt1)
                rr_ptr <= gnt0;

            if (!m1_lock || gnt0)
                lock_held <= 1'b0;
            else if (gnt1)
                lock_held <= 1'b1;

            // The counter only measures how long m0 has been starved by the lock.
            if (!m1_lock || !m0_req_valid || gnt0)
                lock_cnt <= '0;
            else if (gnt1 && lock_cnt != CW'(LOCK_MAX))
                lock_cnt <= lock_cnt + CW'(1);

            vld0_p1 <= gnt0;
            vld1_p1 <= gnt1;
            rd_p1   <= ram_cs && !ram_we;
        end
    end

    // Stage p1: response pulse, read data taken straight from the SRAM output.
    assign m0_rsp_valid = vld0_p1;
    assign m1_rsp_valid = vld1_p1;
    assign m0_rsp_rdata = (vld0_p1 && rd_p1) ? ram_dout : '0;
    assign m1_rsp_rdata = (vld1_p1 && rd_p1) ? ram_dout : '0;

endmodule
